// File: rtl/kernel_pingpong_buf.sv
// kernel_pingpong_buf
// Double-buffered kernel weight store for the convolution datapath. The host
// loads the shadow bank while the active bank streams taps (raster order, all
// output channels side by side) to the MAC array under valid/ready. A commit
// swaps the banks. If a stream is running, the swap waits until the stream ends.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   wr_en/wr_ch/wr_addr/
//   wr_data                 single-cycle write into the shadow bank
//   i_commit                request bank swap (shadow load complete)
//   i_start                 begin streaming the active bank
//   i_num_passes            kernel replays per start (0 behaves as 1)
//   i_ready                 downstream accepts the current beat
//   o_data                  tap of every channel, channel c at [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   o_valid                 o_data valid
//   o_tap_last / o_last     last tap of a pass / last tap of the last pass
//   o_busy                  stream in progress
//   o_commit_pending        swap deferred behind a running stream
//   o_active_valid          active bank holds committed weights
//   o_wr_err                previous-cycle write was rejected
//
// state     | meaning
// ST_IDLE   | no stream; pending swaps execute here, i_start is accepted
// ST_STREAM | presenting beats; advances one tap per handshake
module kernel_pingpong_buf #(
  parameter int KERNEL_SIZE       = 3,
  parameter int NUM_CH            = 4,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int KERNEL_ADDR_WIDTH = 4,
  parameter int CH_ADDR_WIDTH     = 2,
  parameter int PASS_WIDTH        = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           wr_en,
  input  logic [CH_ADDR_WIDTH-1:0]       wr_ch,
  input  logic [KERNEL_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]        wr_data,
  input  logic                           i_commit,
  input  logic                           i_start,
  input  logic [PASS_WIDTH-1:0]          i_num_passes,
  input  logic                           i_ready,
  output logic [NUM_CH*WEIGHT_WIDTH-1:0] o_data,
  output logic                           o_valid,
  output logic                           o_tap_last,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_commit_pending,
  output logic                           o_active_valid,
  output logic                           o_wr_err
);

  localparam int TAPS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CH_DEPTH = 2 ** CH_ADDR_WIDTH;
  localparam int TAP_DEPTH = 2 ** KERNEL_ADDR_WIDTH;
  localparam logic [KERNEL_ADDR_WIDTH-1:0] TAP_LAST = KERNEL_ADDR_WIDTH'(TAPS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Arrays are sized to the full address space so every index is in range;
  // out-of-range writes are rejected before they reach the array.
  logic [WEIGHT_WIDTH-1:0] mem [0:1][0:CH_DEPTH-1][0:TAP_DEPTH-1];

  logic [0:0]                   state;
  logic                         active_sel;
  logic [1:0]                   bank_valid;
  logic                         pending;
  logic [KERNEL_ADDR_WIDTH-1:0] tap;
  logic [PASS_WIDTH-1:0]        pass;
  logic [PASS_WIDTH-1:0]        last_pass;
  logic                         wr_err_q;

  logic in_idle;
  logic in_stream;
  logic swap_now;
  logic eff_valid;
  logic start_ok;
  logic wr_ok;
  logic tap_wrap;
  logic pass_wrap;

  always_comb begin
    in_idle   = (state == ST_IDLE);
    in_stream = (state == ST_STREAM);
    // A deferred swap and a fresh commit both take effect on an idle edge.
    swap_now  = in_idle && (pending || i_commit);
    // The bank a same-cycle start would read is the post-swap active bank.
    eff_valid = swap_now || bank_valid[active_sel];
    start_ok  = in_idle && i_start && eff_valid;
    wr_ok     = wr_en && !pending &&
                (int'(wr_addr) < TAPS) && (int'(wr_ch) < NUM_CH);
    tap_wrap  = (tap == TAP_LAST);
    pass_wrap = (pass == last_pass);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      active_sel <= 1'b0;
      bank_valid <= 2'b00;
      pending    <= 1'b0;
      tap        <= '0;
      pass       <= '0;
      last_pass  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;

      if (swap_now) begin
        active_sel <= ~active_sel;
        // New active = old shadow is marked valid, the new shadow is not.
        bank_valid <= active_sel ? 2'b01 : 2'b10;
        pending    <= 1'b0;
      end else if (in_stream && i_commit) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_STREAM;
            tap       <= '0;
            pass      <= '0;
            last_pass <= (i_num_passes == '0) ? '0 : i_num_passes - 1'b1;
          end
        end
        ST_STREAM: begin
          if (i_ready) begin
            if (tap_wrap) begin
              tap <= '0;
              if (pass_wrap) begin
                state <= ST_IDLE;
              end else begin
                pass <= pass + 1'b1;
              end
            end else begin
              tap <= tap + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes always target the current shadow. With a same-cycle commit that
  // shadow becomes the active bank, so the write is visible to the new stream.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_ok) begin
      mem[~active_sel][wr_ch][wr_addr] <= wr_data;
    end
  end

  // Beat data is read from flop storage addressed by registered tap and bank
  // select. The streaming bank cannot be written (writes go to the shadow, and
  // the swap waits for IDLE), so o_data is stable across stalls.
  always_comb begin
    o_data = '0;
    if (in_stream) begin
      for (int c = 0; c < NUM_CH; c++) begin
        o_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem[active_sel][CH_ADDR_WIDTH'(c)][tap];
      end
    end
  end

  assign o_valid          = in_stream;
  assign o_busy           = in_stream;
  assign o_tap_last       = in_stream && tap_wrap;
  assign o_last           = in_stream && tap_wrap && pass_wrap;
  assign o_commit_pending = pending;
  assign o_active_valid   = bank_valid[active_sel];
  assign o_wr_err         = wr_err_q;

endmodule

// File: tb/tb_kernel_pingpong_buf.sv
module tb_kernel_pingpong_buf;
  localparam int NC  = 4;
  localparam int WW  = 8;
  localparam int KAW = 4;
  localparam int CAW = 2;
  localparam int PW  = 8;
  localparam int T   = 9;
  localparam int DW  = NC * WW;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            wr_en;
  logic [CAW-1:0]  wr_ch;
  logic [KAW-1:0]  wr_addr;
  logic [WW-1:0]   wr_data;
  logic            i_commit;
  logic            i_start;
  logic [PW-1:0]   i_num_passes;
  logic            i_ready;
  logic [DW-1:0]   o_data;
  logic            o_valid;
  logic            o_tap_last;
  logic            o_last;
  logic            o_busy;
  logic            o_commit_pending;
  logic            o_active_valid;
  logic            o_wr_err;

  kernel_pingpong_buf dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .wr_en            (wr_en),
    .wr_ch            (wr_ch),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .i_commit         (i_commit),
    .i_start          (i_start),
    .i_num_passes     (i_num_passes),
    .i_ready          (i_ready),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .o_tap_last       (o_tap_last),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_commit_pending (o_commit_pending),
    .o_active_valid   (o_active_valid),
    .o_wr_err         (o_wr_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tl;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tl;
    logic          last;
    int            cyc;
  } rec_t;

  // Reference model: bank contents, which bank is active, valid flags, the
  // deferred-swap flag and the queue of beats still owed to the consumer.
  logic [WW-1:0] mb [2][NC][16];
  int            m_act;
  logic          m_valid [2];
  logic          m_pend;
  logic          m_err;
  beat_t         mq[$];
  bit            model_on;

  rec_t rec[$];
  int   cyc;
  int   checks;
  int   errors;

  task automatic model_step();
    bit    busy;
    int    p;
    beat_t b;
    if (i_rst) begin
      m_act = 0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      m_pend = 1'b0; m_err = 1'b0; mq.delete(); model_on = 1'b1;
      return;
    end
    if (!model_on) return;
    busy = (mq.size() != 0);
    // A 2-bit channel cannot exceed NUM_CH-1 with four channels.
    m_err = wr_en && ((int'(wr_addr) >= T) || m_pend);
    if (wr_en && !m_err) mb[1-m_act][wr_ch][wr_addr] = wr_data;
    if (busy && i_ready) void'(mq.pop_front());
    if (!busy && (m_pend || i_commit)) begin
      m_act = 1 - m_act;
      m_valid[m_act] = 1'b1;
      m_valid[1-m_act] = 1'b0;
      m_pend = 1'b0;
    end else if (busy && i_commit) begin
      m_pend = 1'b1;
    end
    if (!busy && i_start && m_valid[m_act]) begin
      p = (i_num_passes == 0) ? 1 : int'(i_num_passes);
      for (int k = 0; k < p; k++) begin
        for (int t = 0; t < T; t++) begin
          for (int c = 0; c < NC; c++) b.data[c*WW +: WW] = mb[m_act][c][t];
          b.tl   = (t == T-1);
          b.last = (t == T-1) && (k == p-1);
          mq.push_back(b);
        end
      end
    end
  endtask

  task automatic compare_step();
    logic [DW+6:0] e;
    logic [DW+6:0] a;
    beat_t         f;
    logic          ev;
    if (!model_on) return;
    ev = (mq.size() != 0);
    f  = ev ? mq[0] : '0;
    e = {ev, ev, f.tl, f.last, m_pend, m_valid[m_act], m_err, f.data};
    a = {o_valid, o_busy, o_tap_last, o_last, o_commit_pending, o_active_valid, o_wr_err, o_data};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs cyc=%0d got v=%b busy=%b tl=%b last=%b pend=%b actv=%b werr=%b data=%h want v=%b busy=%b tl=%b last=%b pend=%b actv=%b werr=%b data=%h",
               cyc, a[DW+6], a[DW+5], a[DW+4], a[DW+3], a[DW+2], a[DW+1], a[DW], a[DW-1:0],
               e[DW+6], e[DW+5], e[DW+4], e[DW+3], e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
    end
    if (o_valid && i_ready) rec.push_back({o_data, o_tap_last, o_last, cyc});
  endtask

  task automatic check_lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int addr, input int data);
    wr_en = 1'b1; wr_ch = CAW'(ch); wr_addr = KAW'(addr); wr_data = WW'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit toggle);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      if (toggle) i_ready = ~i_ready;
      tick();
      n++;
    end
    i_ready = 1'b1;
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout got busy=1 want busy=0 within %0d cycles", budget);
    end
  endtask

  task automatic run_stream(input int passes, input bit toggle, input int budget, output int s0);
    rec.delete();
    i_num_passes = PW'(passes);
    i_ready = 1'b1;
    i_start = 1'b1;
    s0 = cyc;
    tick();
    i_start = 1'b0;
    wait_idle(budget, toggle);
  endtask

  initial begin
    int s0;
    int ntl;
    int nlast;
    i_rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
    i_commit = 1'b0; i_start = 1'b0; i_num_passes = 8'd1; i_ready = 1'b0;
    cyc = 0; checks = 0; errors = 0; model_on = 1'b0;
    fork
      forever begin @(posedge i_clk); cyc++; model_step(); end
      forever begin @(negedge i_clk); compare_step(); end
    join_none

    tick(); tick();
    i_rst = 1'b0;
    tick();
    check_lit("rst_valid", {63'd0, o_valid}, 64'd0);
    check_lit("rst_active_valid", {63'd0, o_active_valid}, 64'd0);
    check_lit("rst_data", {32'd0, o_data}, 64'd0);

    // Start with no committed bank is ignored.
    rec.delete();
    i_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    check_lit("nocommit_beats", 64'(rec.size()), 64'd0);
    check_lit("nocommit_busy", {63'd0, o_busy}, 64'd0);

    // Bank A: weight = 16*ch + tap.
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < T; t++) do_write(c, t, 16*c + t);
    do_commit();
    check_lit("commit_active_valid", {63'd0, o_active_valid}, 64'd1);

    run_stream(1, 1'b0, 40, s0);
    check_lit("p1_beats", 64'(rec.size()), 64'd9);
    if (rec.size() == 9) begin
      check_lit("p1_first_latency", 64'(rec[0].cyc), 64'(s0 + 1));
      check_lit("p1_back_to_back", 64'(rec[8].cyc), 64'(s0 + 9));
      check_lit("p1_beat4", {32'd0, rec[4].data}, 64'h34241404);
      check_lit("p1_beat8_flags", {62'd0, rec[8].tl, rec[8].last}, 64'd3);
      check_lit("p1_beat7_flags", {62'd0, rec[7].tl, rec[7].last}, 64'd0);
    end

    // Three passes with ready toggling every cycle.
    run_stream(3, 1'b1, 200, s0);
    check_lit("p3_beats", 64'(rec.size()), 64'd27);
    if (rec.size() == 27) begin
      ntl = 0; nlast = 0;
      foreach (rec[i]) begin
        ntl   += int'(rec[i].tl);
        nlast += int'(rec[i].last);
      end
      check_lit("p3_tap_last_count", 64'(ntl), 64'd3);
      check_lit("p3_last_count", 64'(nlast), 64'd1);
      check_lit("p3_beat17_tl", {63'd0, rec[17].tl}, 64'd1);
      check_lit("p3_beat26_last", {63'd0, rec[26].last}, 64'd1);
      check_lit("p3_beat13", {32'd0, rec[13].data}, 64'h34241404);
    end

    // Load bank B during a long stream of bank A, then commit mid-stream.
    rec.delete();
    i_num_passes = 8'd6; i_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < T; t++) do_write(c, t, 8'hA0 + t);
    do_commit();
    check_lit("midstream_pending", {63'd0, o_commit_pending}, 64'd1);
    do_write(0, 0, 8'hFF);
    check_lit("pending_wr_err", {63'd0, o_wr_err}, 64'd1);
    tick();
    check_lit("wr_err_one_cycle", {63'd0, o_wr_err}, 64'd0);
    wait_idle(100, 1'b0);
    check_lit("p6_beats", 64'(rec.size()), 64'd54);
    if (rec.size() == 54)
      check_lit("p6_still_bank_a", {32'd0, rec[53].data}, 64'h38281808);
    tick();
    check_lit("swap_pending_cleared", {63'd0, o_commit_pending}, 64'd0);
    run_stream(1, 1'b0, 40, s0);
    check_lit("bank_b_beats", 64'(rec.size()), 64'd9);
    if (rec.size() == 9) begin
      check_lit("bank_b_first", {32'd0, rec[0].data}, 64'hA0A0A0A0);
      check_lit("bank_b_last", {32'd0, rec[8].data}, 64'hA8A8A8A8);
    end

    // Out-of-range tap writes are rejected; shadow (bank A) stays intact.
    do_write(0, 9, 8'h55);
    check_lit("addr9_wr_err", {63'd0, o_wr_err}, 64'd1);
    do_write(2, 15, 8'h66);
    check_lit("addr15_wr_err", {63'd0, o_wr_err}, 64'd1);
    do_write(1, 3, 8'h13);
    check_lit("good_wr_no_err", {63'd0, o_wr_err}, 64'd0);
    do_commit();
    run_stream(1, 1'b0, 40, s0);
    if (rec.size() == 9) begin
      check_lit("readback_tap0", {32'd0, rec[0].data}, 64'h30201000);
      check_lit("readback_tap3", {32'd0, rec[3].data}, 64'h33231303);
    end else begin
      check_lit("readback_beats", 64'(rec.size()), 64'd9);
    end

    // Reset while beat 5 is on the bus.
    rec.delete();
    i_num_passes = 8'd1; i_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_lit("midrst_valid", {63'd0, o_valid}, 64'd0);
    check_lit("midrst_active_valid", {63'd0, o_active_valid}, 64'd0);
    check_lit("midrst_beats_seen", 64'(rec.size()), 64'd6);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    check_lit("midrst_start_ignored", {63'd0, o_busy}, 64'd0);

    // Random traffic against the model.
    repeat (4000) begin
      i_rst        = ($urandom_range(0, 199) == 0);
      wr_en        = ($urandom_range(0, 2) == 0);
      wr_ch        = CAW'($urandom);
      wr_addr      = KAW'($urandom_range(0, 15));
      wr_data      = WW'($urandom);
      i_commit     = ($urandom_range(0, 19) == 0);
      i_start      = ($urandom_range(0, 7) == 0);
      i_ready      = ($urandom_range(0, 9) < 7);
      i_num_passes = PW'($urandom_range(0, 3));
      tick();
    end
    i_rst = 1'b0; wr_en = 1'b0; i_commit = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
